mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/edulent_pkg.sv | 23 ++
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/rr_pick2.sv | 23 ++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/edulent_pkg.sv
// Shared types for the memory arbiter: access owners, FSM states
// and the round-robin helper.
package edulent_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // DBG as the reset owner lets the CPU win the first tie
    localparam owner_e RST_LAST_OWNER = OWN_DBG;

    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_CPU) ? OWN_DBG : OWN_CPU;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, debug-loader and memory-side signals of the arbiter.
// slave = arbiter side, master = environment side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              i_cpu_req;
    logic              i_cpu_we;
    logic [ADDR_W-1:0] i_cpu_addr;
    logic [DATA_W-1:0] i_cpu_wdata;

    logic              i_dbg_req;
    logic              i_dbg_we;
    logic [ADDR_W-1:0] i_dbg_addr;
    logic [DATA_W-1:0] i_dbg_wdata;
    logic              i_dbg_halt;

    logic              o_cpu_gnt;
    logic              o_dbg_gnt;
    logic              o_cpu_done;
    logic              o_dbg_done;
    logic [DATA_W-1:0] o_rdata;

    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_data_write;
    logic              o_mem_write_enable;
    logic [DATA_W-1:0] i_mem_data_read;

    modport slave (
        input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
        input  i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
        input  i_dbg_halt, i_mem_data_read,
        output o_cpu_gnt, o_dbg_gnt, o_cpu_done, o_dbg_done,
        output o_rdata, o_mem_addr, o_mem_data_write,
        output o_mem_write_enable
    );

    modport master (
        output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
        output i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
        output i_dbg_halt, i_mem_data_read,
        input  o_cpu_gnt, o_dbg_gnt, o_cpu_done, o_dbg_done,
        input  o_rdata, o_mem_addr, o_mem_data_write,
        input  o_mem_write_enable
    );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick between CPU and debug requests.
// On a tie the requester that did not win last time is chosen.
module rr_pick2
    import edulent_pkg::*;
(
    input  logic   i_cpu_el,
    input  logic   i_dbg_el,
    input  owner_e i_last,
    output logic   o_vld,
    output owner_e o_win
);

    always_comb begin
        o_vld = i_cpu_el | i_dbg_el;
        o_win = OWN_CPU;
        if (i_cpu_el && i_dbg_el) begin
            o_win = other_owner(i_last);
        end else if (i_dbg_el) begin
            o_win = OWN_DBG;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU and debug-loader accesses onto one synchronous
// single-port memory, one access in flight (IDLE -> ACCESS -> RESP).
module mem_arbiter
    import edulent_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    mem_arbiter_if.slave  bus
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              cpu_el;
    logic              dbg_el;
    logic              pick_vld;
    owner_e            pick_own;

    logic              cpu_gnt;
    logic              dbg_gnt;
    logic              cpu_done;
    logic              dbg_done;
    logic              mem_we;
    logic [DATA_W-1:0] rdata;

    // A halted CPU is simply invisible to the picker
    assign cpu_el = bus.i_cpu_req & ~bus.i_dbg_halt;
    assign dbg_el = bus.i_dbg_req;

    rr_pick2 u_pick (
        .i_cpu_el (cpu_el),
        .i_dbg_el (dbg_el),
        .i_last   (last_q),
        .o_vld    (pick_vld),
        .o_win    (pick_own)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cpu_gnt  = 1'b0;
        dbg_gnt  = 1'b0;
        cpu_done = 1'b0;
        dbg_done = 1'b0;
        mem_we   = 1'b0;
        rdata    = '0;

        unique case (state_q)
            ST_IDLE: begin
                // Grant is combinational, so keep it quiet in reset
                if (pick_vld && i_rstn) begin
                    owner_d = pick_own;
                    last_d  = pick_own;
                    state_d = ST_ACCESS;
                    if (pick_own == OWN_DBG) begin
                        we_d    = bus.i_dbg_we;
                        addr_d  = bus.i_dbg_addr;
                        wdata_d = bus.i_dbg_wdata;
                        dbg_gnt = 1'b1;
                    end else begin
                        we_d    = bus.i_cpu_we;
                        addr_d  = bus.i_cpu_addr;
                        wdata_d = bus.i_cpu_wdata;
                        cpu_gnt = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                mem_we  = we_q;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (owner_q == OWN_DBG) begin
                    dbg_done = 1'b1;
                end else begin
                    cpu_done = 1'b1;
                end
                if (!we_q) begin
                    rdata = bus.i_mem_data_read;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_CPU;
            last_q  <= RST_LAST_OWNER;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.o_cpu_gnt          = cpu_gnt;
    assign bus.o_dbg_gnt          = dbg_gnt;
    assign bus.o_cpu_done         = cpu_done;
    assign bus.o_dbg_done         = dbg_done;
    assign bus.o_rdata            = rdata;
    assign bus.o_mem_write_enable = mem_we;
    assign bus.o_mem_addr         = addr_q;
    assign bus.o_mem_data_write   = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model feeding a scoreboard,
// directed scenarios followed by randomized traffic.
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   cyc  = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    typedef struct {
        int          cyc;
        bit          own;
        bit          we;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } exp_t;

    typedef struct {
        int cyc;
        bit own;
    } g_t;

    exp_t exp_q[$];
    g_t   glog[$];

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic       pl_en   = 1'b0;
    logic [7:0] pl_addr = '0;
    logic [7:0] pl_data = '0;

    function automatic logic [7:0] init_val(input int a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    // Synchronous single-port memory attached to the arbiter
    always @(posedge clk) begin
        if (cyc < 2) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end
        if (pl_en) mem[pl_addr] <= pl_data;
        if (bus.o_mem_write_enable) mem[bus.o_mem_addr] <= bus.o_mem_data_write;
        bus.i_mem_data_read <= mem[bus.o_mem_addr];
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Reference model: one access per 3 cycles, halted CPU ineligible,
    // tie goes to whoever did not win last.
    int free_cyc = 0;
    bit last_own = 1'b1;

    always @(negedge clk) begin : model
        bit   ce, de, gv, gw;
        exp_t e;
        if (!rstn) begin
            exp_q.delete();
            last_own = 1'b1;
            free_cyc = 0;
        end else begin
            ce = bus.i_cpu_req && !bus.i_dbg_halt;
            de = bus.i_dbg_req;
            gv = (cyc >= free_cyc) && (ce || de);
            gw = (ce && de) ? !last_own : de;
            chk("gnt", {bus.o_cpu_gnt, bus.o_dbg_gnt}, {gv && !gw, gv && gw});
            if (gv) begin
                e.cyc   = cyc;
                e.own   = gw;
                e.we    = gw ? bus.i_dbg_we : bus.i_cpu_we;
                e.addr  = gw ? bus.i_dbg_addr : bus.i_cpu_addr;
                e.wdata = gw ? bus.i_dbg_wdata : bus.i_cpu_wdata;
                e.rdata = e.we ? 8'h00 : ref_mem[e.addr];
                exp_q.push_back(e);
                last_own = gw;
                free_cyc = cyc + 3;
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rstn) begin
            chk("reset_outputs",
                {bus.o_cpu_gnt, bus.o_dbg_gnt, bus.o_cpu_done, bus.o_dbg_done,
                 bus.o_mem_write_enable, bus.o_rdata, bus.o_mem_addr,
                 bus.o_mem_data_write}, 64'h0);
        end else begin
            if (bus.o_cpu_gnt) glog.push_back(g_t'{cyc, 1'b0});
            if (bus.o_dbg_gnt) glog.push_back(g_t'{cyc, 1'b1});
            if (exp_q.size() > 0 && exp_q[0].cyc + 2 < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL done_missing: access granted at %0d never completed", exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc + 1 == cyc) begin
                e = exp_q[0];
                chk("mem_access",
                    {bus.o_mem_write_enable, bus.o_mem_addr,
                     bus.o_mem_write_enable ? bus.o_mem_data_write : 8'h00},
                    {e.we, e.addr, e.we ? e.wdata : 8'h00});
            end else begin
                chk("mem_we_quiet", bus.o_mem_write_enable, 1'b0);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc + 2 == cyc) begin
                e = exp_q.pop_front();
                chk("done_rdata", {bus.o_cpu_done, bus.o_dbg_done, bus.o_rdata},
                    {~e.own, e.own, e.rdata});
                if (e.we) ref_mem[e.addr] = e.wdata;
            end else begin
                chk("no_done", {bus.o_cpu_done, bus.o_dbg_done}, 2'b00);
            end
        end
    end

    task automatic set_req(input bit own, input bit r, input bit we,
                           input logic [7:0] a, input logic [7:0] d);
        if (own) begin
            bus.i_dbg_req = r; bus.i_dbg_we = we;
            bus.i_dbg_addr = a; bus.i_dbg_wdata = d;
        end else begin
            bus.i_cpu_req = r; bus.i_cpu_we = we;
            bus.i_cpu_addr = a; bus.i_cpu_wdata = d;
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        ref_mem[a] = d;
        pl_addr = a; pl_data = d; pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Called just after a rising edge; returns after done, at the next IDLE
    task automatic issue(input bit own, input bit we, input logic [7:0] a,
                         input logic [7:0] d, output logic [7:0] rd);
        int gc;
        bit ok;
        rd = '0;
        gc = 0;
        set_req(own, 1'b1, we, a, d);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (own ? bus.o_dbg_gnt : bus.o_cpu_gnt) begin
                ok = 1'b1; gc = cyc; break;
            end
        end
        chk("issue_gnt_seen", ok, 1'b1);
        @(posedge clk); #1;
        set_req(own, 1'b0, 1'b0, 8'h00, 8'h00);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (own ? bus.o_dbg_done : bus.o_cpu_done) begin
                ok = 1'b1; rd = bus.o_rdata;
                chk("done_latency", cyc - gc, 2);
                break;
            end
            @(negedge clk);
        end
        chk("issue_done_seen", ok, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rstn = 1'b0;
        repeat (n) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] rd;
        bit cg, dg, ok;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        bus.i_dbg_halt = 1'b0;
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        preload(8'h10, 8'hA5);
        rstn = 1'b1;

        // CPU read of preloaded location
        issue(1'b0, 1'b0, 8'h10, 8'h00, rd);
        chk("cpu_read_a5", rd, 8'hA5);

        // Debug write then CPU read-back
        issue(1'b1, 1'b1, 8'h20, 8'h3C, rd);
        issue(1'b0, 1'b0, 8'h20, 8'h00, rd);
        chk("readback_3c", rd, 8'h3C);
        chk("mem_20_written", mem[8'h20], 8'h3C);

        // Both continuously requesting right after reset
        @(posedge clk); #1;
        rstn = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
        set_req(1'b1, 1'b1, 1'b0, 8'h02, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        glog.delete();
        rstn = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("alt_count", glog.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < glog.size(); i++) begin
            chk("alt_owner", glog[i].own, i[0]);
            chk("alt_spacing", glog[i].cyc - glog[0].cyc, 3 * i);
        end

        // Halt: only debug is served, CPU wins once halt drops
        bus.i_dbg_halt = 1'b1;
        set_req(1'b0, 1'b1, 1'b1, 8'h40, 8'h11);
        set_req(1'b1, 1'b1, 1'b0, 8'h41, 8'h00);
        glog.delete();
        repeat (12) @(posedge clk);
        #1;
        chk("halt_dbg_count", glog.size() >= 3, 1'b1);
        foreach (glog[i]) chk("halt_only_dbg", glog[i].own, 1'b1);
        bus.i_dbg_halt = 1'b0;
        glog.delete();
        repeat (4) @(posedge clk);
        #1;
        chk("unhalt_cpu_first", (glog.size() > 0) && (glog[0].own == 1'b0), 1'b1);
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (4) @(posedge clk);
        #1;

        // Reset during ACCESS of a CPU write
        set_req(1'b0, 1'b1, 1'b1, 8'h05, 8'h77);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.o_cpu_gnt) begin ok = 1'b1; break; end
        end
        chk("rst_case_gnt", ok, 1'b1);
        @(posedge clk); #2;
        rstn = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        chk("rst_mid_outputs",
            {bus.o_cpu_done, bus.o_mem_write_enable, bus.o_mem_addr,
             bus.o_mem_data_write, bus.o_rdata}, 64'h0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mem_05_untouched", mem[8'h05], init_val(5));

        // CPU withdraws while debug access is in flight
        set_req(1'b1, 1'b1, 1'b1, 8'h30, 8'h5A);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.o_dbg_gnt) begin ok = 1'b1; break; end
        end
        chk("wd_dbg_gnt", ok, 1'b1);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b0, 1'b1, 1'b1, 8'h31, 8'hEE);
        glog.delete();
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (5) @(posedge clk);
        #1;
        chk("wd_no_grant", glog.size(), 0);
        chk("wd_mem_31", mem[8'h31], init_val(8'h31));

        // Randomized traffic
        cg = 1'b0;
        dg = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!bus.i_cpu_req || cg) begin
                set_req(1'b0, ($urandom % 3) != 0, 1'($urandom % 2),
                        8'($urandom % 16), 8'($urandom));
            end else if ($urandom % 10 == 0) begin
                bus.i_cpu_req = 1'b0;
            end
            if (!bus.i_dbg_req || dg) begin
                set_req(1'b1, ($urandom % 3) != 0, 1'($urandom % 2),
                        8'($urandom % 16), 8'($urandom));
            end else if ($urandom % 10 == 0) begin
                bus.i_dbg_req = 1'b0;
            end
            if ($urandom % 8 == 0) bus.i_dbg_halt = ~bus.i_dbg_halt;
            @(negedge clk);
            cg = bus.o_cpu_gnt;
            dg = bus.o_dbg_gnt;
            @(posedge clk); #1;
        end

        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        bus.i_dbg_halt = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
